// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Also holds a helper that sizes the iteration counter from the operand width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    function automatic int cnt_width(int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Conditional two's-complement negate: magnitude of signed operands on the way in,
// sign restoration of products/quotients/remainders on the way out.
module muldiv_sign_adjust #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, signs fixed up at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mc_q, mc_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix, mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic               div_ge, sgn_op_q, neg_res;

    muldiv_sign_adjust #(.W(WIDTH)) u_abs_a (
        .val_i(a), .neg_i(~op[0] & a[WIDTH-1]), .val_o(a_mag));
    muldiv_sign_adjust #(.W(WIDTH)) u_abs_b (
        .val_i(b), .neg_i(~op[0] & b[WIDTH-1]), .val_o(b_mag));

    assign sgn_op_q = ~op_q[0];
    assign neg_res  = sgn_op_q & (sa_q ^ sb_q);

    muldiv_sign_adjust #(.W(2*WIDTH)) u_fix_prod (
        .val_i(acc_q), .neg_i(neg_res), .val_o(prod_fix));
    muldiv_sign_adjust #(.W(WIDTH)) u_fix_quo (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res), .val_o(quo_fix));
    // Truncating division: the remainder follows the dividend's sign.
    muldiv_sign_adjust #(.W(WIDTH)) u_fix_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sgn_op_q & sa_q), .val_o(rem_fix));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mc_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}, shifted left.
    // Remainder stays below the divisor, so the borrow bit alone decides the compare.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, mc_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0],
                        acc_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        mc_d    = mc_q;
        a_d     = a_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    sa_d    = ~op[0] & a[WIDTH-1];
                    sb_d    = ~op[0] & b[WIDTH-1];
                    bz_d    = (b == '0);
                    a_d     = a;
                    if (op[1]) begin
                        mc_d  = b_mag;
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        mc_d  = a_mag;
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            mc_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            done_q  <= done_d;
            mc_q    <= mc_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency and
// handshake behaviour, MTHI/MTLO gating and asynchronous reset mid-operation.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Starts one operation and watches 40 cycles after the start edge.
    // disturb >= 0: at that cycle, pulse start with other operands plus MTHI/MTLO.
    // we_start: drive MTHI/MTLO in the same cycle as the accepted start.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int disturb, input bit we_start);
        logic [31:0] prev_hi, prev_lo, got_hi, got_lo;
        int busy_n, done_n, done_at;
        busy_n = 0; done_n = 0; done_at = -1; got_hi = '0; got_lo = '0;
        @(negedge clk);
        prev_hi = hi; prev_lo = lo;
        start = 1'b1; op = o; a = ia; b = ib;
        if (we_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEADBEEF;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++; done_at = i; got_hi = hi; got_lo = lo;
            end
            if (i == 20) begin
                chk({tag, " hi_hold"}, hi, prev_hi);
                chk({tag, " lo_hold"}, lo, prev_lo);
            end
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            op = 2'($urandom); a = $urandom; b = $urandom;
            if (i == disturb) begin
                start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5A5A5;
            end
        end
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, " done_count"}, 32'(done_n), 32'd1);
        chk({tag, " done_at"}, 32'(done_at), 32'd33);
        chk({tag, " hi"}, got_hi, exp_hi);
        chk({tag, " lo"}, got_lo, exp_lo);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hi", hi, 32'h0);
        chk("rst lo", lo, 32'h0);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1, 1'b0);
        run_op("mult_m3x5", OP_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1, 1'b0);
        run_op("multu_m3x5", OP_MULTU, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, -1, 1'b0);
        run_op("div_m7_2", OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1, 1'b0);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, -1, 1'b0);
        run_op("div_by0", OP_DIV, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, -1, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'h80000005, 32'h0, 32'h80000005, 32'hFFFFFFFF, -1, 1'b0);
        run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, -1, 1'b0);

        // Restart and MTHI/MTLO while busy must not disturb the operation in flight.
        run_op("busy_restart", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0);
        // MTHI/MTLO alongside an accepted start are dropped.
        run_op("we_with_start", OP_MULTU, 32'd3, 32'd3, 32'd0, 32'd9, -1, 1'b1);

        @(negedge clk);
        hi_we = 1'b1; wd = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi hi", hi, 32'hA5A5A5A5);
        chk("mthi lo", lo, 32'd9);
        chk("mthi done", 32'(done), 32'd0);
        lo_we = 1'b1; wd = 32'h5A5A5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo lo", lo, 32'h5A5A5A5A);
        chk("mtlo hi", hi, 32'hA5A5A5A5);
        chk("mtlo done", 32'(done), 32'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst hi", hi, 32'h0);
        chk("midrst lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Operands come straight from register-file read ports rd1/rd2.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over a fixed multi-cycle latency, with a start/busy/done handshake.
- HI/LO results feed the register-file write-data mux (via MFHI/MFLO) under control-unit steering.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; accepted only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  input  WIDTH  operand A / dividend (from rd1).
- b  input  WIDTH  operand B / divisor (from rd2).
- hi_we  input  1  MTHI: write wd into HI.
- lo_we  input  1  MTLO: write wd into LO.
- wd  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register (remainder / product upper half).
- lo  output  WIDTH  LO register (quotient / product lower half).

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n. Assertion forces state IDLE immediately: busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
- States:
  - IDLE: wait for start.
  - RUN: WIDTH iterations.
  - FINISH: sign fixup and HI/LO write.
- IDLE→RUN: on the edge where start=1 (edge E0). Latch op, |a| and |b| (two's-complement magnitude for signed ops, raw for unsigned), sign of a, sign of b, and a b==0 flag. busy=1 from E0.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, counter 0..WIDTH-1. Steps occur at E1..E32. Transition to FINISH after the step with counter=WIDTH-1.
- FINISH→IDLE at E33:
  - hi/lo loaded with the final result, done=1 for exactly one cycle, busy=0.
  - Total: start edge to result edge = 33 cycles; the next start is accepted at E33+1 at the earliest.
- Multiply: 2·WIDTH-bit unsigned product of magnitudes. Signed op with sign(a)≠sign(b) → negate the full 64-bit product. hi=upper WIDTH bits, lo=lower WIDTH bits.
- Divide: unsigned quotient/remainder of magnitudes.
  - Signed op: quotient negated if sign(a)≠sign(b); remainder takes the sign of a (truncating division).
  - Divisor zero (both DIV/DIVU): lo=all ones, hi=a (original, unmodified); same 33-cycle latency.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm; no special case.
- start while busy=1: ignored, no effect on the operation in flight.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0. HI/LO update at the next edge; done stays 0.
  - Ignored while busy, or in the same cycle as an accepted start.
- Operands a/b/op are don't-care after E0.
- hi/lo hold their previous values throughout RUN. They change only at FINISH, on MTHI/MTLO, or on reset.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings (S_IDLE, S_RUN, S_FINISH), counter width.
- One natural sub-module, muldiv_sign_adjust: combinational magnitude/negate helper used for operand abs() and result fixup. The FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → 33 cycles after start edge: done pulse, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1.
- DIV a=0x12345678 b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshakes:
  - start pulsed again at RUN iteration 5 with different operands → first result unaffected, single done.
  - hi_we with wd=0xA5A5A5A5 while busy → ignored.
  - Same write in IDLE → hi=0xA5A5A5A5 next edge, no done.
- Assert rst_n=0 mid-RUN (iteration 10) → busy, done, hi, lo all 0 immediately. After release, MULTU 6×7 → lo=42, hi=0 after 33 cycles.
